// File: rtl/receiver3b_pkg.sv
// Shared definitions for the 3-byte framed serial link (transmitter and receiver).
package receiver3b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int FRAME_BITS      = 8;
  localparam int FRAMES_PER_WORD = 3;
  localparam int WORD_BITS       = FRAME_BITS * FRAMES_PER_WORD;

endpackage

// File: rtl/receiver3b_rx_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; resets to 1.
module rx_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receiver3b.sv
// Oversampling receiver that reassembles three start/8-data/stop frames into one word.
// Optional inter-frame gap timeout is compiled in with RX_TIMEOUT_EN.
module receiver3b
  import receiver3b_pkg::*;
#(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                 baud_rate,
  input  logic                 reset,
  input  logic                 in,
  output logic [0:WORD_BITS-1] data,
  output logic                 data_received,
  output logic                 framing_error,
  output logic [1:0]           state_out
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [4:0]    LAST_IDX  = 5'(WORD_BITS - 1);

  logic line;

  rx_sync2 u_sync (
    .clk   (baud_rate),
    .reset (reset),
    .d     (in),
    .q     (line)
  );

  rx_state_e              state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [4:0]             bit_q, bit_d;
  logic [1:0]             frame_q, frame_d;
  logic                   armed_q, armed_d;
  logic [0:WORD_BITS-1]   word_q, word_d;
  logic [0:WORD_BITS-1]   data_q, data_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;

`ifdef RX_TIMEOUT_EN
  localparam int GAP_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int GW        = $clog2(GAP_LIMIT + 1);
  logic [GW-1:0] gap_q, gap_d;
`endif

  // data_received is a one-cycle valid strobe with no back-pressure; data holds until the next one.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    armed_d = armed_q;
    word_d  = word_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (line) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick_q == HALF_LAST) begin
          tick_d  = '0;
          state_d = line ? IDLE : DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_q == FULL_LAST) begin
          tick_d                   = '0;
          word_d[LAST_IDX - bit_q] = line;
          bit_d                    = bit_q + 5'd1;
          if (bit_q[2:0] == 3'(FRAME_BITS - 1)) state_d = STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_q == FULL_LAST) begin
          tick_d  = '0;
          state_d = IDLE;
          if (!line) begin
            ferr_d  = 1'b1;
            frame_d = '0;
            bit_d   = '0;
            armed_d = 1'b0;
          end else if (frame_q == 2'(FRAMES_PER_WORD - 1)) begin
            data_d  = word_q;
            done_d  = 1'b1;
            frame_d = '0;
            bit_d   = '0;
          end else begin
            frame_d = frame_q + 2'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef RX_TIMEOUT_EN
    // Gap only accrues while a partial word is parked in IDLE.
    gap_d = '0;
    if (state_q == IDLE && state_d == IDLE && frame_q != 2'd0) begin
      if (gap_q == GW'(GAP_LIMIT - 1)) begin
        ferr_d  = 1'b1;
        frame_d = '0;
        bit_d   = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge baud_rate) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      armed_q <= 1'b0;
      word_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_TIMEOUT_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      armed_q <= armed_d;
      word_q  <= word_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef RX_TIMEOUT_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign data          = data_q;
  assign data_received = done_q;
  assign framing_error = ferr_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_receiver3b.sv
// Self-checking bench for receiver3b: a behavioural transmitter drives the line, a monitor scores words.
module tb_receiver3b;

  localparam int OS = 16;

  logic        baud_rate = 1'b0;
  logic        reset     = 1'b1;
  logic        ser_in    = 1'b1;
  logic [0:23] data;
  logic        data_received;
  logic        framing_error;
  logic [1:0]  state_out;

  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rx_cnt   = 0;
  int          ferr_cnt = 0;
  int          exp_rx   = 0;
  int          exp_ferr = 0;
  logic [23:0] last_word = 24'h0;
  logic        prev_rx   = 1'b0;
  logic        prev_ferr = 1'b0;

  receiver3b #(.OVERSAMPLE(OS), .TIMEOUT_BITS(32)) dut (
    .baud_rate     (baud_rate),
    .reset         (reset),
    .in            (ser_in),
    .data          (data),
    .data_received (data_received),
    .framing_error (framing_error),
    .state_out     (state_out)
  );

  // clock / watchdog
  always #5 baud_rate = ~baud_rate;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge baud_rate);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_in = b;
    repeat (OS) tick();
  endtask

  task automatic idle_bits(input int n);
    ser_in = 1'b1;
    repeat (n * OS) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_word(input logic [23:0] w);
    exp_q.push_back(w);
    exp_rx++;
    last_word = w;
    send_frame(w[7:0], 1'b1);
    send_frame(w[15:8], 1'b1);
    send_frame(w[23:16], 1'b1);
  endtask

  task automatic wait_rx(input int target);
    for (int i = 0; i < 2000 && rx_cnt < target; i++) tick();
    check("rx_count", 32'(rx_cnt), 32'(target));
  endtask

  // scoreboard monitor
  always @(negedge baud_rate) begin
    if (data_received || framing_error)
      check("rx_ferr_exclusive", 32'(data_received & framing_error), 32'd0);
    if (data_received) begin
      check("rx_pulse_width", 32'(prev_rx), 32'd0);
      rx_cnt++;
      if (exp_q.size() > 0) check("rx_data", 32'(data), 32'(exp_q.pop_front()));
    end
    if (framing_error) begin
      check("ferr_pulse_width", 32'(prev_ferr), 32'd0);
      ferr_cnt++;
    end
    prev_rx   = data_received;
    prev_ferr = framing_error;
  end

  initial begin
    // reset state
    reset  = 1'b1;
    ser_in = 1'b1;
    repeat (5) tick();
    @(negedge baud_rate);
    check("reset_data", 32'(data), 32'd0);
    check("reset_rx", 32'(data_received), 32'd0);
    check("reset_ferr", 32'(framing_error), 32'd0);
    check("reset_state", 32'(state_out), 32'd0);
    tick();
    reset = 1'b0;
    idle_bits(2);

    // single word
    send_word(24'hA5C30F);
    idle_bits(2);
    wait_rx(exp_rx);
    check("ferr_after_a5c30f", 32'(ferr_cnt), 32'(exp_ferr));

    // back-to-back words, no idle gap
    send_word(24'h000001);
    send_word(24'hFFFFFE);
    idle_bits(2);
    wait_rx(exp_rx);
    check("ferr_after_b2b", 32'(ferr_cnt), 32'(exp_ferr));

    // 3-tick glitch on idle line: false start
    ser_in = 1'b0;
    repeat (3) tick();
    ser_in = 1'b1;
    repeat (3) tick();
    @(negedge baud_rate);
    check("glitch_in_start", 32'(state_out), 32'd1);
    repeat (20) tick();
    @(negedge baud_rate);
    check("glitch_back_idle", 32'(state_out), 32'd0);
    check("glitch_data_held", 32'(data), 32'(last_word));
    check("glitch_no_rx", 32'(rx_cnt), 32'(exp_rx));
    check("glitch_no_ferr", 32'(ferr_cnt), 32'(exp_ferr));

    // bad stop bit on second frame, then a clean word
    send_frame(8'h11, 1'b1);
    exp_ferr++;
    send_frame(8'h22, 1'b0);
    idle_bits(3);
    check("bad_stop_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check("bad_stop_idle", 32'(state_out), 32'd0);
    check("bad_stop_no_rx", 32'(rx_cnt), 32'(exp_rx));
    send_word(24'h123456);
    idle_bits(2);
    wait_rx(exp_rx);

    // reset during DATA of the third frame
    send_frame(8'h3C, 1'b1);
    send_frame(8'h5A, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("pre_reset_state", 32'(state_out), 32'd2);
    reset = 1'b1;
    tick();
    @(negedge baud_rate);
    check("midreset_data", 32'(data), 32'd0);
    check("midreset_state", 32'(state_out), 32'd0);
    check("midreset_rx", 32'(data_received), 32'd0);
    check("midreset_ferr", 32'(framing_error), 32'd0);
    tick();
    reset = 1'b0;
    idle_bits(2);
    check("post_reset_no_rx", 32'(rx_cnt), 32'(exp_rx));
    check("post_reset_no_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    send_word(24'h5A3C96);
    idle_bits(2);
    wait_rx(exp_rx);

    // long inter-frame gap
`ifdef RX_TIMEOUT_EN
    send_frame(8'hEE, 1'b1);
    exp_ferr++;
    idle_bits(33);
    check("timeout_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check("timeout_no_rx", 32'(rx_cnt), 32'(exp_rx));
    send_word(24'hC0FFEE);
`else
    exp_q.push_back(24'hC0FFEE);
    exp_rx++;
    send_frame(8'hEE, 1'b1);
    idle_bits(33);
    check("gap_no_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check("gap_idle", 32'(state_out), 32'd0);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hC0, 1'b1);
`endif
    idle_bits(2);
    wait_rx(exp_rx);

    // final report
    check("final_ferr_count", 32'(ferr_cnt), 32'(exp_ferr));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
